axis_pkt_fifo: RTL and testbench
================================

Name: axis_pkt_fifo

Overview:
Parametrised AXI-Stream output FIFO, the next generation of the convolution engine's output buffer. Adds:
- TLAST carriage
- optional store-and-forward packet mode
- occupancy, almost-full and stored-packet-count status
- optional back-pressure statistics

Sits between the convolution datapath and the output AXIS port. One clock domain.

Parameters:
DATAW, 24, payload bits per word (TLAST stored alongside, storage width DATAW+1)
DEPTH, 38, number of entries; any integer >= 2, not restricted to powers of two
AFULL_LVL, 34, almost_full asserts when level >= AFULL_LVL; legal range 1..DEPTH
PKT_MODE, 0, 0 = cut-through; 1 = store-and-forward (output only complete packets)
CNTW, $clog2(DEPTH+1), derived (localparam); width of level and pkt_count

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
IN_AXIS_TDATA  in  DATAW  write payload
IN_AXIS_TLAST  in  1  end-of-packet marker, stored with payload
IN_AXIS_TVALID  in  1  write request
IN_AXIS_TREADY  out  1  FIFO can accept
OUT_AXIS_TDATA  out  DATAW  head-of-FIFO payload
OUT_AXIS_TLAST  out  1  head-of-FIFO TLAST
OUT_AXIS_TVALID  out  1  head word presentable
OUT_AXIS_TREADY  in  1  downstream accepts
level  out  CNTW  words currently stored
almost_full  out  1  level >= AFULL_LVL
pkt_count  out  CNTW  stored words with TLAST=1
stall_cnt  out  16  back-pressure cycle count (see Optional Feature)

Behaviour:
- Reset: head=tail=0, level=0, pkt_count=0, stall_cnt=0. OUT_AXIS_TVALID=0, IN_AXIS_TREADY=1, almost_full=0. OUT_AXIS_TDATA/TLAST are don't-care while TVALID=0.
- Reset mid-operation discards all contents in one cycle; no partial pops.
- Handshake rules:
  - push = IN_AXIS_TVALID & IN_AXIS_TREADY
  - pop = OUT_AXIS_TVALID & OUT_AXIS_TREADY
  - TVALID and TDATA must not depend combinationally on the same-side TREADY.
- IN_AXIS_TREADY = (level < DEPTH) | pop. A push is accepted while full if a pop occurs in the same cycle.
- Pointers increment on push/pop and wrap from DEPTH-1 to 0.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a word pushed at edge N is presentable (TVALID may assert) from cycle N+1. This includes push into an empty FIFO, so write-to-read bypass is required when the read address equals the write address.
- Storage uses registered-read memory with a look-ahead read address: tail+1 (wrapped) when popping, else tail. Back-to-back pops deliver one word per cycle with no bubbles.
- OUT_AXIS_TDATA/TLAST must be stable while TVALID=1 and TREADY=0.
- pkt_count: +1 on push with TLAST=1, -1 on pop with TLAST=1, unchanged when both occur.
- Cut-through (PKT_MODE=0): OUT_AXIS_TVALID = (level != 0).
- Store-and-forward (PKT_MODE=1): OUT_AXIS_TVALID = (level != 0) & (pkt_count != 0 | release). The release flag prevents deadlock on oversize packets:
  - set when level==DEPTH and pkt_count==0
  - cleared on pop of a TLAST word or on reset
  - once set, the oversize packet streams cut-through until its TLAST leaves.
- almost_full and level are registered-consistent with the pointer state (reflect the post-edge count).
- Overflow and underflow are impossible by construction; push while full without a pop is refused (TREADY=0).

Optional Feature:
- Macro: AXIS_PKT_FIFO_STATS_EN.
- Defined: stall_cnt is a 16-bit counter that increments each cycle IN_AXIS_TVALID=1 and IN_AXIS_TREADY=0. It saturates at 16'hFFFF and clears only on reset.
- Undefined: stall_cnt tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset then push 1 word (TDATA=24'h00ABCD, TLAST=0) with OUT_TREADY=0 -> TVALID=1 the next cycle, TDATA=24'h00ABCD, level=1.
- DEPTH=38, push 0..37 with OUT_TREADY=0 -> after 38 pushes level=38, IN_TREADY=0, almost_full=1 (asserted from level 34). Then hold IN_TVALID with OUT_TREADY=1 for 20 cycles -> one push and one pop per cycle, level stays 38, output order 0,1,2,...
- Continuous push and pop of 100 incrementing words across multiple wraps -> output exactly 0..99 in order, no gaps after the first word, level never exceeds 2.
- PKT_MODE=1: push 3 words with TLAST only on the third, OUT_TREADY=1 -> TVALID stays 0 until the cycle after the TLAST push, then 3 consecutive words with TLAST on the last; pkt_count goes 0->1->0.
- PKT_MODE=1: push 38 words with no TLAST -> release set, output drains cut-through. Push TLAST on word 40 -> release clears after that word pops; a following 2-word packet waits for its TLAST.
- Stats: with AXIS_PKT_FIFO_STATS_EN defined, full FIFO plus IN_TVALID=1 and OUT_TREADY=0 for 10 cycles -> stall_cnt=10. With the macro undefined, stall_cnt=0.

Source files
------------

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream output FIFO with TLAST carriage, optional store-and-forward packet mode and status outputs.
// Build option: define AXIS_PKT_FIFO_STATS_EN to add the saturating back-pressure counter on stall_cnt.
module axis_pkt_fifo #(
   parameter int DATAW     = 24,
   parameter int DEPTH     = 38,
   parameter int AFULL_LVL = 34,
   parameter int PKT_MODE  = 0,
   localparam int CNTW     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DATAW-1:0] IN_AXIS_TDATA,
   input  logic             IN_AXIS_TLAST,
   input  logic             IN_AXIS_TVALID,
   output logic             IN_AXIS_TREADY,
   output logic [DATAW-1:0] OUT_AXIS_TDATA,
   output logic             OUT_AXIS_TLAST,
   output logic             OUT_AXIS_TVALID,
   input  logic             OUT_AXIS_TREADY,
   output logic [CNTW-1:0]  level,
   output logic             almost_full,
   output logic [CNTW-1:0]  pkt_count,
   output logic [15:0]      stall_cnt
);

   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);
   localparam logic [CNTW-1:0] FULL_LVL = CNTW'(DEPTH);
   localparam logic [CNTW-1:0] AF_LVL   = CNTW'(AFULL_LVL);

   typedef logic [DATAW:0] word_t;

   word_t           mem [DEPTH];
   word_t           rd_word;
   word_t           wr_word;
   logic [PTRW-1:0] head, tail, head_inc, tail_inc, rd_addr;
   logic [CNTW-1:0] level_q, level_d, pkt_q, pkt_d;
   logic            af_q;
   logic            rel_q, rel_d;
   logic            out_valid, in_ready, push, pop, push_last, pop_last;

   function automatic logic [PTRW-1:0] wrap_inc(input logic [PTRW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      out_valid = (level_q != '0);
      // Store-and-forward holds the head back until a whole packet (or an oversize release) is present.
      if (PKT_MODE != 0) begin
         out_valid = out_valid & ((pkt_q != '0) | rel_q);
      end
   end

   assign pop       = out_valid & OUT_AXIS_TREADY;
   assign in_ready  = (level_q != FULL_LVL) | pop;
   assign push      = IN_AXIS_TVALID & in_ready;
   assign push_last = push & IN_AXIS_TLAST;
   assign pop_last  = pop & rd_word[DATAW];
   assign wr_word   = {IN_AXIS_TLAST, IN_AXIS_TDATA};
   assign head_inc  = wrap_inc(head);
   assign tail_inc  = wrap_inc(tail);
   assign rd_addr   = pop ? tail_inc : tail;

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
   end

   always_comb begin
      pkt_d = pkt_q;
      if (push_last && !pop_last) begin
         pkt_d = pkt_q + 1'b1;
      end else if (pop_last && !push_last) begin
         pkt_d = pkt_q - 1'b1;
      end
   end

   // Full with no packet boundary inside: let the oversize packet through cut-through until its TLAST leaves.
   always_comb begin
      rel_d = rel_q;
      if (pop_last) begin
         rel_d = 1'b0;
      end else if (level_q == FULL_LVL && pkt_q == '0) begin
         rel_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[head] <= wr_word;
      end
   end

   // Look-ahead registered read; bypass covers a word written into the slot being fetched.
   always_ff @(posedge clk) begin
      if (push && (head == rd_addr)) begin
         rd_word <= wr_word;
      end else begin
         rd_word <= mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         level_q <= '0;
         pkt_q   <= '0;
         af_q    <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         if (push) begin
            head <= head_inc;
         end
         if (pop) begin
            tail <= tail_inc;
         end
         level_q <= level_d;
         pkt_q   <= pkt_d;
         af_q    <= (level_d >= AF_LVL);
         rel_q   <= rel_d;
      end
   end

`ifdef AXIS_PKT_FIFO_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (IN_AXIS_TVALID && !in_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

   assign IN_AXIS_TREADY  = in_ready;
   assign OUT_AXIS_TDATA  = rd_word[DATAW-1:0];
   assign OUT_AXIS_TLAST  = rd_word[DATAW];
   assign OUT_AXIS_TVALID = out_valid;
   assign level           = level_q;
   assign almost_full     = af_q;
   assign pkt_count       = pkt_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: a cut-through and a store-and-forward instance, each checked every cycle
// against a queue model, plus directed vectors with hand-computed expectations.
module tb_axis_pkt_fifo;

   localparam int DATAW     = 24;
   localparam int DEPTH     = 38;
   localparam int AFULL_LVL = 34;
   localparam int CNTW      = $clog2(DEPTH + 1);

   typedef logic [DATAW:0] word_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [DATAW-1:0] in_data   [2];
   logic             in_last   [2];
   logic             in_valid  [2];
   logic             in_ready  [2];
   logic [DATAW-1:0] out_data  [2];
   logic             out_last  [2];
   logic             out_valid [2];
   logic             out_ready [2];
   logic [CNTW-1:0]  level     [2];
   logic             afull     [2];
   logic [CNTW-1:0]  pkt_count [2];
   logic [15:0]      stall     [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL inst%0d %s: got 0x%0h, expected 0x%0h at %0t", g, nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : gen_inst
      axis_pkt_fifo #(
         .DATAW(DATAW), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL), .PKT_MODE(g)
      ) u_dut (
         .clk(clk),
         .reset(reset),
         .IN_AXIS_TDATA(in_data[g]),
         .IN_AXIS_TLAST(in_last[g]),
         .IN_AXIS_TVALID(in_valid[g]),
         .IN_AXIS_TREADY(in_ready[g]),
         .OUT_AXIS_TDATA(out_data[g]),
         .OUT_AXIS_TLAST(out_last[g]),
         .OUT_AXIS_TVALID(out_valid[g]),
         .OUT_AXIS_TREADY(out_ready[g]),
         .level(level[g]),
         .almost_full(afull[g]),
         .pkt_count(pkt_count[g]),
         .stall_cnt(stall[g])
      );

      word_t mq [$];
      bit    m_rel   = 1'b0;
      int    m_stall = 0;

      // Queue model: outputs derived from the queue contents, then advanced by this cycle's handshakes.
      always begin : model
         int n, np;
         bit mv, mpop, mrdy, mpush;
         @(negedge clk);
         #2;
         if (reset) begin
            mq.delete();
            m_rel   = 1'b0;
            m_stall = 0;
         end else begin
            n  = mq.size();
            np = 0;
            foreach (mq[i]) if (mq[i][DATAW]) np++;
            mv    = (n != 0) && (g == 0 || np != 0 || m_rel);
            mpop  = mv && out_ready[g];
            mrdy  = (n < DEPTH) || mpop;
            mpush = in_valid[g] && mrdy;
            chk(g, "level", 32'(level[g]), 32'(n));
            chk(g, "pkt_count", 32'(pkt_count[g]), 32'(np));
            chk(g, "almost_full", 32'(afull[g]), 32'(n >= AFULL_LVL));
            chk(g, "out_valid", 32'(out_valid[g]), 32'(mv));
            chk(g, "in_ready", 32'(in_ready[g]), 32'(mrdy));
            if (mv) begin
               chk(g, "out_data", 32'(out_data[g]), 32'(mq[0][DATAW-1:0]));
               chk(g, "out_last", 32'(out_last[g]), 32'(mq[0][DATAW]));
            end
`ifdef AXIS_PKT_FIFO_STATS_EN
            chk(g, "stall_cnt", 32'(stall[g]), 32'(m_stall));
`else
            chk(g, "stall_cnt", 32'(stall[g]), 32'd0);
`endif
            if (in_valid[g] && !mrdy && m_stall < 65535) m_stall++;
            if (mpop && mq[0][DATAW]) m_rel = 1'b0;
            else if (n == DEPTH && np == 0) m_rel = 1'b1;
            if (mpop) void'(mq.pop_front());
            if (mpush) mq.push_back({in_last[g], in_data[g]});
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input int g, input int maxc);
      int c;
      c = 0;
      in_valid[g]  = 1'b0;
      in_last[g]   = 1'b0;
      out_ready[g] = 1'b1;
      while (out_valid[g] && c < maxc) begin
         step();
         c++;
      end
      chk(g, "drain_done", 32'(out_valid[g]), 32'd0);
      chk(g, "drain_level", 32'(level[g]), 32'd0);
      out_ready[g] = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      n_err++;
      $display("FAIL watchdog: time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : stim
      int    c, got, gaps, maxlvl, npop;
      word_t lastw;

      reset = 1'b1;
      for (int g = 0; g < 2; g++) begin
         in_data[g]   = '0;
         in_last[g]   = 1'b0;
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b0;
      end
      step();
      step();

      chk(0, "rst_level", 32'(level[0]), 32'd0);
      chk(0, "rst_out_valid", 32'(out_valid[0]), 32'd0);
      chk(0, "rst_in_ready", 32'(in_ready[0]), 32'd1);
      chk(0, "rst_afull", 32'(afull[0]), 32'd0);
      chk(0, "rst_pkt_count", 32'(pkt_count[0]), 32'd0);
      chk(0, "rst_stall", 32'(stall[0]), 32'd0);
      reset = 1'b0;

      // Single word into an empty FIFO is presentable the next cycle.
      in_valid[0] = 1'b1;
      in_data[0]  = 24'h00ABCD;
      step();
      chk(0, "first_valid", 32'(out_valid[0]), 32'd1);
      chk(0, "first_data", 32'(out_data[0]), 32'h0000ABCD);
      chk(0, "first_level", 32'(level[0]), 32'd1);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      step();
      chk(0, "first_popped", 32'(level[0]), 32'd0);
      out_ready[0] = 1'b0;

      // Fill to DEPTH, then push and pop together while full.
      for (int i = 0; i < 38; i++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 24'(i);
         step();
         chk(0, "af_fill", 32'(afull[0]), (i + 1 >= 34) ? 32'd1 : 32'd0);
      end
      chk(0, "full_level", 32'(level[0]), 32'd38);
      chk(0, "full_in_ready", 32'(in_ready[0]), 32'd0);
      chk(0, "full_afull", 32'(afull[0]), 32'd1);
      chk(0, "full_head", 32'(out_data[0]), 32'd0);
      out_ready[0] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in_data[0] = 24'(38 + k);
         step();
         chk(0, "full_pp_data", 32'(out_data[0]), 32'(k + 1));
         chk(0, "full_pp_level", 32'(level[0]), 32'd38);
      end
      drain(0, 60);

      // 100-word stream through a nearly empty FIFO across several wraps.
      out_ready[0] = 1'b1;
      got = 0; gaps = 0; maxlvl = 0; c = 0;
      while (got < 100 && c < 300) begin
         in_valid[0] = (c < 100);
         in_data[0]  = 24'(c);
         in_last[0]  = 1'b0;
         step();
         c++;
         if (int'(level[0]) > maxlvl) maxlvl = int'(level[0]);
         if (out_valid[0]) begin
            chk(0, "stream_data", 32'(out_data[0]), 32'(got));
            got++;
         end else if (got > 0) begin
            gaps++;
         end
      end
      in_valid[0] = 1'b0;
      chk(0, "stream_count", 32'(got), 32'd100);
      chk(0, "stream_gaps", 32'(gaps), 32'd0);
      chk(0, "stream_maxlvl_le2", 32'(maxlvl <= 2), 32'd1);
      drain(0, 5);

      // Reset mid-operation discards everything at once.
      for (int i = 0; i < 5; i++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 24'h000500 + 24'(i);
         in_last[0]  = (i == 2);
         step();
      end
      in_valid[0] = 1'b0;
      in_last[0]  = 1'b0;
      chk(0, "pre_rst_level", 32'(level[0]), 32'd5);
      chk(0, "pre_rst_pkt", 32'(pkt_count[0]), 32'd1);
      reset = 1'b1;
      step();
      chk(0, "mid_rst_level", 32'(level[0]), 32'd0);
      chk(0, "mid_rst_valid", 32'(out_valid[0]), 32'd0);
      chk(0, "mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
      chk(0, "mid_rst_pkt", 32'(pkt_count[0]), 32'd0);
      reset = 1'b0;

      // Store-and-forward: nothing leaves until the TLAST word is in.
      out_ready[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[1] = 1'b1;
         in_data[1]  = 24'h000011 * 24'(i + 1);
         in_last[1]  = (i == 2);
         step();
         chk(1, "sf_valid", 32'(out_valid[1]), (i == 2) ? 32'd1 : 32'd0);
         chk(1, "sf_pkt", 32'(pkt_count[1]), (i == 2) ? 32'd1 : 32'd0);
      end
      in_valid[1] = 1'b0;
      in_last[1]  = 1'b0;
      chk(1, "sf_w0", 32'(out_data[1]), 32'h00000011);
      step();
      chk(1, "sf_w1", 32'(out_data[1]), 32'h00000022);
      chk(1, "sf_w1_last", 32'(out_last[1]), 32'd0);
      step();
      chk(1, "sf_w2", 32'(out_data[1]), 32'h00000033);
      chk(1, "sf_w2_last", 32'(out_last[1]), 32'd1);
      step();
      chk(1, "sf_done_valid", 32'(out_valid[1]), 32'd0);
      chk(1, "sf_done_pkt", 32'(pkt_count[1]), 32'd0);
      out_ready[1] = 1'b0;

      // Oversize packet: full with no TLAST must release and stream through.
      for (int i = 0; i < 38; i++) begin
         in_valid[1] = 1'b1;
         in_data[1]  = 24'h000600 + 24'(i);
         in_last[1]  = 1'b0;
         step();
      end
      in_valid[1] = 1'b0;
      chk(1, "ovr_level", 32'(level[1]), 32'd38);
      chk(1, "ovr_held", 32'(out_valid[1]), 32'd0);
      step();
      chk(1, "ovr_release", 32'(out_valid[1]), 32'd1);
      out_ready[1] = 1'b1;
      npop = 0; c = 0; lastw = '0;
      while ((c < 2 || out_valid[1]) && c < 100) begin
         if (out_valid[1]) begin
            npop++;
            lastw = {out_last[1], out_data[1]};
         end
         in_valid[1] = (c < 2);
         in_data[1]  = 24'h000626 + 24'(c);
         in_last[1]  = (c == 1);
         step();
         c++;
      end
      in_valid[1] = 1'b0;
      in_last[1]  = 1'b0;
      chk(1, "ovr_pops", 32'(npop), 32'd40);
      chk(1, "ovr_last_word", 32'(lastw), 32'h01000627);
      chk(1, "ovr_level_end", 32'(level[1]), 32'd0);

      // After release clears, a new packet waits for its TLAST again.
      in_valid[1] = 1'b1;
      in_data[1]  = 24'h000701;
      step();
      in_valid[1] = 1'b0;
      chk(1, "post_rel_hold0", 32'(out_valid[1]), 32'd0);
      step();
      chk(1, "post_rel_hold1", 32'(out_valid[1]), 32'd0);
      in_valid[1] = 1'b1;
      in_data[1]  = 24'h000702;
      in_last[1]  = 1'b1;
      step();
      in_valid[1] = 1'b0;
      in_last[1]  = 1'b0;
      chk(1, "post_rel_valid", 32'(out_valid[1]), 32'd1);
      chk(1, "post_rel_data", 32'(out_data[1]), 32'h00000701);
      drain(1, 10);

      // Back-pressure statistics: 10 refused cycles on a full FIFO.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 38; i++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 24'h000800 + 24'(i);
         step();
      end
      chk(0, "stats_pre", 32'(stall[0]), 32'd0);
      for (int i = 0; i < 10; i++) step();
      in_valid[0] = 1'b0;
`ifdef AXIS_PKT_FIFO_STATS_EN
      chk(0, "stats_cnt", 32'(stall[0]), 32'd10);
`else
      chk(0, "stats_cnt", 32'(stall[0]), 32'd0);
`endif
      chk(0, "stats_level", 32'(level[0]), 32'd38);
      drain(0, 60);

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
